// File: rtl/sum_deskew_if.sv
// Bundles the skewed adder stream going in and the aligned, frame-tagged words coming out.
// The producer side uses the master modport; the deskew block uses the slave modport.
interface sum_deskew_if #(
    parameter int W  = 8,
    parameter int CW = 3
);
    logic [W:0]    s_in;
    logic          in_valid;
    logic          in_first;
    logic [W:0]    out_word;
    logic          out_valid;
    logic [CW-1:0] out_idx;
    logic          out_last;

    modport master (
        output s_in, in_valid, in_first,
        input  out_word, out_valid, out_idx, out_last
    );

    modport slave (
        input  s_in, in_valid, in_first,
        output out_word, out_valid, out_idx, out_last
    );
endinterface

// File: rtl/sum_deskew.sv
// Realigns the diagonally skewed sum lanes of a bit-sliced adder into parallel result words.
// Each output word is also tagged with its position inside a DCT coefficient frame.
module sum_deskew #(
    parameter int W     = 8,
    parameter int FRAME = 8,
    parameter int CW    = 3
) (
    input  logic         clk,
    input  logic         rst,
    sum_deskew_if.slave  bus
);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
    localparam logic [CW-1:0] ONE_IDX  = CW'(1);

    logic [W-2:0] tap;

    // Lane i arrives i cycles late, so it needs W-1-i stages to catch up with lane W-1.
    for (genvar i = 0; i <= W - 2; i++) begin : g_lane
        localparam int D = W - 1 - i;
        logic [D-1:0] dly_q;
        logic [D-1:0] dly_d;

        always_comb begin
            dly_d[0] = bus.s_in[i];
            for (int j = 1; j < D; j++) begin
                dly_d[j] = dly_q[j-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly_q <= '0;
            end else begin
                dly_q <= dly_d;
            end
        end

        assign tap[i] = dly_q[D-1];
    end

    logic [W-2:0] vld_q, vld_d;
    logic [W-2:0] fst_q, fst_d;

    always_comb begin
        vld_d[0] = bus.in_valid;
        fst_d[0] = bus.in_valid & bus.in_first;
        for (int j = 1; j <= W - 2; j++) begin
            vld_d[j] = vld_q[j-1];
            fst_d[j] = fst_q[j-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            fst_q <= '0;
        end else begin
            vld_q <= vld_d;
            fst_q <= fst_d;
        end
    end

    logic          dly_vld;
    logic          dly_fst;
    logic [W:0]    word_q, word_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign dly_vld = vld_q[W-2];
    assign dly_fst = fst_q[W-2];

    // A frame start overrides the wrap, so a short frame never leaks into the next one.
    always_comb begin
        word_d  = {bus.s_in[W], bus.s_in[W-1], tap};
        valid_d = dly_vld;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = 1'b0;
        if (dly_vld) begin
            if (dly_fst) begin
                idx_d = '0;
                cnt_d = ONE_IDX;
            end else begin
                idx_d = cnt_q;
                cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + ONE_IDX;
            end
            last_d = (idx_d == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_word  = word_q;
    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_sum_deskew.sv
// Drives skewed result streams built from per-result tables and checks the aligned output words,
// frame indices and last flags, including bubbles, lane isolation, frame restarts and async reset.
module tb_sum_deskew;
    localparam int W     = 8;
    localparam int FRAME = 8;
    localparam int CW    = 3;
    localparam int MAXS  = 256;

    typedef logic [W:0] word_t;

    typedef struct {
        logic          vld;
        logic          fst;
        word_t         word;
        logic [CW-1:0] exp_idx;
        logic          exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    sum_deskew_if #(.W(W), .CW(CW)) bus ();

    sum_deskew #(.W(W), .FRAME(FRAME), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl [MAXS];
    int   tbl_n;
    int   checks = 0;
    int   errors = 0;
    bit   fill_ones = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic vld, input logic fst, input word_t w,
                                input int idx, input logic last);
        tbl[tbl_n].vld      = vld;
        tbl[tbl_n].fst      = fst;
        tbl[tbl_n].word     = w;
        tbl[tbl_n].exp_idx  = CW'(idx);
        tbl[tbl_n].exp_last = last;
        tbl_n++;
    endfunction

    // Applies the table as a skewed stream; result s puts bit i on lane i at edge s+i.
    task automatic run_seq(input string tag, input int rst_edge);
        for (int c = 0; c < tbl_n + W; c++) begin
            word_t s;
            int    src;
            for (int i = 0; i <= W; i++) begin
                src = c - ((i == W) ? W - 1 : i);
                if (src >= 0 && src < tbl_n && tbl[src].vld)
                    s[i] = tbl[src].word[i];
                else
                    s[i] = fill_ones ? 1'b1 : 1'($urandom);
            end
            bus.s_in     = s;
            bus.in_valid = (c < tbl_n) ? tbl[c].vld : 1'b0;
            bus.in_first = (c < tbl_n) ? tbl[c].fst : 1'($urandom);
            @(posedge clk);
            #1;
            src = c - (W - 1);
            if (src >= 0 && src < tbl_n && tbl[src].vld) begin
                chk($sformatf("%s[%0d] valid", tag, src), int'(bus.out_valid), 1);
                chk($sformatf("%s[%0d] word", tag, src), int'(bus.out_word), int'(tbl[src].word));
                chk($sformatf("%s[%0d] idx", tag, src), int'(bus.out_idx), int'(tbl[src].exp_idx));
                chk($sformatf("%s[%0d] last", tag, src), int'(bus.out_last), int'(tbl[src].exp_last));
            end else begin
                chk($sformatf("%s edge%0d idle valid", tag, c), int'(bus.out_valid), 0);
                chk($sformatf("%s edge%0d idle last", tag, c), int'(bus.out_last), 0);
            end
            if (c == rst_edge) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, " async rst valid"}, int'(bus.out_valid), 0);
                chk({tag, " async rst word"}, int'(bus.out_word), 0);
                chk({tag, " async rst idx"}, int'(bus.out_idx), 0);
                chk({tag, " async rst last"}, int'(bus.out_last), 0);
                @(posedge clk);
                #1;
                chk({tag, " held rst valid"}, int'(bus.out_valid), 0);
                chk({tag, " held rst word"}, int'(bus.out_word), 0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int   model_cnt;
        int   pos;
        word_t w;

        rst          = 1'b1;
        bus.s_in     = '0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        #12;
        chk("reset valid", int'(bus.out_valid), 0);
        chk("reset word", int'(bus.out_word), 0);
        chk("reset idx", int'(bus.out_idx), 0);
        chk("reset last", int'(bus.out_last), 0);
        @(negedge clk);
        rst = 1'b0;

        tbl_n = 0;
        add(1'b1, 1'b1, word_t'(9'h0A5), 0, 1'b0);
        run_seq("single", -1);

        tbl_n = 0;
        for (int i = 0; i < 16; i++)
            add(1'b1, (i % FRAME) == 0, word_t'(256 + i), i % FRAME, (i % FRAME) == FRAME - 1);
        run_seq("b2b", -1);

        fill_ones = 1'b1;
        tbl_n = 0;
        for (int k = 0; k <= W; k++) begin
            w = word_t'(1) << k;
            add(1'b1, k == 0, w, k % FRAME, k == FRAME - 1);
            add(1'b0, 1'b0, '0, 0, 1'b0);
            add(1'b0, 1'b0, '0, 0, 1'b0);
        end
        run_seq("walk1", -1);
        fill_ones = 1'b0;

        tbl_n = 0;
        add(1'b1, 1'b1, word_t'($urandom), 0, 1'b0);
        add(1'b0, 1'b1, '0, 0, 1'b0);
        add(1'b0, 1'b0, '0, 0, 1'b0);
        add(1'b1, 1'b0, word_t'($urandom), 1, 1'b0);
        add(1'b1, 1'b0, word_t'($urandom), 2, 1'b0);
        run_seq("bubble", -1);

        tbl_n = 0;
        for (int i = 0; i < 12; i++)
            add(1'b1, i == 0 || i == 4, word_t'($urandom), (i < 4) ? i : i - 4, i == 11);
        run_seq("refirst", -1);

        for (int r = 0; r < 2; r++) begin
            tbl_n     = 0;
            model_cnt = 0;
            for (int s = 0; s < 200; s++) begin
                logic v;
                logic f;
                v = (s == 0) || ($urandom_range(0, 9) < 7);
                f = (s == 0) || ($urandom_range(0, 4) == 0);
                pos = 0;
                if (v) begin
                    pos       = f ? 0 : model_cnt;
                    model_cnt = (pos + 1) % FRAME;
                end
                add(v, f, word_t'($urandom), pos, v && pos == FRAME - 1);
            end
            run_seq($sformatf("rand%0d", r), -1);
        end

        tbl_n = 0;
        add(1'b1, 1'b1, word_t'(9'h1C3), 0, 1'b0);
        add(1'b0, 1'b0, '0, 0, 1'b0);
        add(1'b0, 1'b0, '0, 0, 1'b0);
        add(1'b0, 1'b0, '0, 0, 1'b0);
        add(1'b1, 1'b0, word_t'(9'h0FF), 1, 1'b0);
        run_seq("midrst", W - 1);

        tbl_n = 0;
        add(1'b1, 1'b0, word_t'(9'h07E), 0, 1'b0);
        run_seq("postrst", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_deskew.md
Name: sum_deskew

Overview:
- Reassembles the diagonally skewed, bit-serial sum stream from the pipelined bit-sliced adder into parallel result words.
- The adder emits bit i of a given result i cycles after bit 0. This block delays each bit lane so all W+1 bits of one result leave together on one registered word.
- It also tracks 1D-DCT coefficient frames, so downstream transpose/storage logic gets a word-aligned, frame-tagged stream.

Parameters:
- W, 8, operand width: number of skewed sum lanes. Legal range W >= 2.
- FRAME, 8, results per DCT frame, used for the index/last flags. Legal range FRAME >= 2.
- CW, 3, frame index width. Must satisfy 2**CW >= FRAME.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- s_in  input  W+1  skewed adder output: [W-1:0] sum lanes, [W] carry lane (aligned with lane W-1).
- in_valid  input  1  bit 0 of a new result is present on s_in[0] this cycle.
- in_first  input  1  qualifies in_valid: this result starts a new frame.
- out_word  output  W+1  deskewed result: {carry, sum[W-1:0]}.
- out_valid  output  1  out_word holds a complete result.
- out_idx  output  CW  position of out_word within its frame, 0..FRAME-1.
- out_last  output  1  out_idx == FRAME-1 while out_valid.

Behaviour:
- Reset (async, active-high): all delay registers, out_word, out_valid, out_idx, out_last and the frame counter go to 0 immediately and stay there while rst is high. First capture is the first rising edge after rst deasserts.
- Lane skew: if bit 0 of result n is sampled at edge k, bit i of n is on s_in[i] at edge k+i. The carry s_in[W] is sampled at edge k+W-1.
- Delay lines:
  - Lane i (0 <= i <= W-2) passes through W-1-i free-running shift registers, then the output register.
  - Lane W-1 and the carry lane load the output register directly.
  - Total delay regs = W(W-1)/2.
- Control pipeline: in_valid and in_first travel through a W-1 deep shift register alongside lane 0.
- Latency: out_word/out_valid update on edge k+W-1 (7 edges for W=8). Throughput is one result per cycle. Back-to-back in_valid is legal.
- Gaps: pipeline always shifts and has no stall input. Lanes shift in whatever is on s_in; only the delayed valid qualifies the output.
  - out_valid = 0 during bubbles.
  - out_word is don't-care when out_valid = 0, but it is still registered each cycle (no X after reset).
- Frame counter (CW bits), advances only when the delayed valid is 1:
  - delayed first = 1 → out_idx = 0, counter = 1.
  - Otherwise out_idx = counter; counter increments and wraps FRAME-1 → 0.
  - Simultaneous wrap and delayed first: first wins, out_idx = 0.
  - in_first with in_valid = 0 is ignored.
- out_last is registered and asserts only together with out_valid.
- Bits are treated as opaque: no arithmetic or sign handling. Two's-complement interpretation of the carry is the consumer's job.
- Reset mid-stream: all in-flight partial results are discarded. No out_valid for any result whose bit 0 was sampled before reset release.

Test Plan:
- Single result 0x0A5 (carry 0, sum 0xA5) skewed over edges k..k+7, in_valid/in_first at k → out_valid for exactly one cycle after edge k+7; out_word = 0x0A5, out_idx = 0, out_last = 0.
- 16 back-to-back skewed results 0x100..0x10F, in_first on results 0 and 8 → 16 consecutive out_valid cycles with correct words; out_idx runs 0..7 twice; out_last on 0x107 and 0x10F only.
- Lane isolation: walking-one per lane, with all other lanes driven to the complement of the expected bit in off-diagonal cycles → each output has exactly one set bit at the right position. Carry 1 with sum 0x00 → out_word = 0x100.
- Bubbles: results at k, k+3, k+4 with in_valid low otherwise and s_in randomized during gaps → out_valid after edges k+7, k+10, k+11 only, all words correct.
- in_first mid-frame at the 5th result → out_idx sequence 0,1,2,3,0,1,...; out_last follows the new alignment.
- Async reset pulsed between clock edges after result bit 3 is sampled → outputs 0 immediately. No out_valid for that result. A new result sent afterwards emerges after 7 edges with out_idx = 0.
